// File: rtl/mem_io_bridge_pkg.sv
// Shared types and address map for the CPU memory/I-O bridge.
package mem_io_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned RAM_AW = 8;
    localparam int unsigned SW_W   = 8;
    localparam int unsigned LED_W  = 8;

    localparam logic [ADDR_W-1:0] LED_ADDR = 9'h100;
    localparam logic [ADDR_W-1:0] SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } mem_cmd_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        RESP    = 2'b10
    } bridge_state_t;

    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_LED,
        DEC_SW,
        DEC_NONE
    } region_t;

    // RAM occupies the lower half; the upper half holds only two registers.
    function automatic region_t decode(input logic [ADDR_W-1:0] addr);
        if (!addr[ADDR_W-1])    return DEC_RAM;
        else if (addr == LED_ADDR) return DEC_LED;
        else if (addr == SW_ADDR)  return DEC_SW;
        else                       return DEC_NONE;
    endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU-side memory bus between the CPU and the bridge.
interface mem_io_bridge_if;
    import mem_io_pkg::*;

    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, mem_ready
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, mem_ready
    );
endinterface

// File: rtl/mem_io_bridge_sync2.sv
// Two-flop synchroniser for asynchronous board inputs.
module sync2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/mem_io_bridge.sv
// Decodes CPU accesses to RAM / LED / switches, sequences RAM reads and
// returns a one-cycle mem_ready; also holds sticky halt and bus error flags.
module mem_io_bridge
    import mem_io_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mem_io_bridge_if.slave    cpu,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [SW_W-1:0]   sw,
    input  logic              halt,
    output logic [8:0]        ledr,
    output logic              bus_err
);
    bridge_state_t     state_q, state_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic              bus_err_q, bus_err_d;
    logic              mem_ready_q;
    logic              halt_q;
    logic              ram_we_c;
    logic [SW_W-1:0]   sw_sync;
    region_t           region;

    sync2 #(.W(SW_W)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (sw),
        .q_o   (sw_sync)
    );

    assign region = decode(cpu.mem_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            read_data_q <= '0;
            led_q       <= '0;
            bus_err_q   <= 1'b0;
            mem_ready_q <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
            led_q       <= led_d;
            bus_err_q   <= bus_err_d;
            mem_ready_q <= (state_d == RESP);
            halt_q      <= halt_q | halt;
        end
    end

    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        led_d       = led_q;
        bus_err_d   = bus_err_q;
        ram_we_c    = 1'b0;
        case (state_q)
            IDLE: begin
                case (cpu.mem_cmd)
                    MREAD: begin
                        if (region == DEC_RAM) begin
                            state_d = RD_WAIT;
                        end else if (region == DEC_SW) begin
                            read_data_d = {8'h00, sw_sync};
                            state_d     = RESP;
                        end else begin
                            read_data_d = '0;
                            bus_err_d   = 1'b1;
                            state_d     = RESP;
                        end
                    end
                    MWRITE: begin
                        if (region == DEC_RAM) begin
                            ram_we_c = 1'b1;
                        end else if (region == DEC_LED) begin
                            led_d = cpu.write_data[LED_W-1:0];
                        end else begin
                            bus_err_d = 1'b1;
                        end
                        state_d = RESP;
                    end
                    2'b11:   bus_err_d = 1'b1;
                    default: ;
                endcase
            end
            RD_WAIT: begin
                read_data_d = ram_rdata;
                state_d     = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ram_addr      = cpu.mem_addr[RAM_AW-1:0];
    assign ram_wdata     = cpu.write_data;
    // The write strobe is combinational, so gate it off while reset is held.
    assign ram_we        = ram_we_c & ~reset;
    assign cpu.read_data = read_data_q;
    assign cpu.mem_ready = mem_ready_q;
    assign ledr          = {halt_q, led_q};
    assign bus_err       = bus_err_q;
endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed self-checking bench for mem_io_bridge with a behavioural 1-cycle RAM.
module tb_mem_io_bridge;
    import mem_io_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [SW_W-1:0]   sw;
    logic              halt;
    logic [8:0]        ledr;
    logic              bus_err;

    logic [DATA_W-1:0] ram_mem [256];
    logic              pl_we;
    logic [RAM_AW-1:0] pl_addr;
    logic [DATA_W-1:0] pl_data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_io_bridge_if bus ();

    mem_io_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .cpu       (bus),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .sw        (sw),
        .halt      (halt),
        .ledr      (ledr),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM with a bench-side preload port.
    always_ff @(posedge clk) begin
        if (pl_we)       ram_mem[pl_addr] <= pl_data;
        else if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one access; report cycles to mem_ready (-1 on timeout), write strobes seen
    // and the RAM address presented during the accepting cycle.
    task automatic access(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, output int lat, output int we_cnt,
                          output logic [RAM_AW-1:0] ra);
        @(negedge clk);
        bus.mem_cmd    = cmd;
        bus.mem_addr   = addr;
        bus.write_data = wd;
        #1;
        we_cnt = int'(ram_we);
        ra     = ram_addr;
        lat    = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) begin
                lat = i;
                break;
            end
            we_cnt += int'(ram_we);
        end
        @(negedge clk);
        bus.mem_cmd = MNONE;
    endtask

    task automatic check_ready_dropped(input string tag);
        @(posedge clk);
        #1;
        check(tag, 32'(bus.mem_ready), 32'd0);
    endtask

    int                lat, wec, rdy_cnt;
    logic [RAM_AW-1:0] ra;

    initial begin
        reset          = 1'b1;
        bus.mem_cmd    = MNONE;
        bus.mem_addr   = '0;
        bus.write_data = '0;
        sw             = '0;
        halt           = 1'b0;
        pl_we          = 1'b1;
        pl_addr        = 8'h05;
        pl_data        = 16'h0032;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        check("rst_read_data", 32'(bus.read_data), 32'd0);
        check("rst_ledr",      32'(ledr),          32'd0);
        check("rst_bus_err",   32'(bus_err),       32'd0);
        check("rst_ram_we",    32'(ram_we),        32'd0);
        @(negedge clk);
        pl_we = 1'b0;
        reset = 1'b0;

        // RAM read
        access(MREAD, 9'h005, 16'h0000, lat, wec, ra);
        check("rd05_lat",  32'(lat), 32'd2);
        check("rd05_data", 32'(bus.read_data), 32'h0032);
        check_ready_dropped("rd05_ready_low");

        // RAM write then read at the top RAM address
        access(MWRITE, 9'h0FF, 16'hBEEF, lat, wec, ra);
        check("wrff_lat",     32'(lat), 32'd1);
        check("wrff_we_cnt",  32'(wec), 32'd1);
        check("wrff_ramaddr", 32'(ra),  32'hFF);
        check("wrff_rdhold",  32'(bus.read_data), 32'h0032);
        access(MREAD, 9'h0FF, 16'h0000, lat, wec, ra);
        check("rdff_lat",  32'(lat), 32'd2);
        check("rdff_data", 32'(bus.read_data), 32'hBEEF);

        // LED write
        access(MWRITE, LED_ADDR, 16'h12A5, lat, wec, ra);
        check("led_lat",    32'(lat),  32'd1);
        check("led_ledr",   32'(ledr), 32'h0A5);
        check("led_we_cnt", 32'(wec),  32'd0);
        check("led_rdhold", 32'(bus.read_data), 32'hBEEF);

        // Switch read after synchroniser delay
        @(negedge clk);
        sw = 8'h3C;
        repeat (2) @(posedge clk);
        access(MREAD, SW_ADDR, 16'h0000, lat, wec, ra);
        check("sw_lat",     32'(lat), 32'd1);
        check("sw_data",    32'(bus.read_data), 32'h003C);
        check("sw_bus_err", 32'(bus_err), 32'd0);

        // Unmapped read
        access(MREAD, 9'h1FF, 16'h0000, lat, wec, ra);
        check("unm_lat",     32'(lat), 32'd1);
        check("unm_data",    32'(bus.read_data), 32'd0);
        check("unm_bus_err", 32'(bus_err), 32'd1);

        // Illegal command: no completion
        @(negedge clk);
        bus.mem_cmd  = 2'b11;
        bus.mem_addr = 9'h005;
        rdy_cnt = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            rdy_cnt += int'(bus.mem_ready);
        end
        check("ill_no_ready", 32'(rdy_cnt), 32'd0);
        check("ill_bus_err",  32'(bus_err), 32'd1);
        @(negedge clk);
        bus.mem_cmd = MNONE;

        // Write to the read-only switch port
        access(MWRITE, SW_ADDR, 16'h00FF, lat, wec, ra);
        check("wsw_lat",  32'(lat),  32'd1);
        check("wsw_ledr", 32'(ledr), 32'h0A5);

        // Halt pulse is sticky and does not block traffic
        @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("halt_ledr8", 32'(ledr[8]), 32'd1);
        access(MREAD, 9'h005, 16'h0000, lat, wec, ra);
        check("halt_rd_lat",  32'(lat), 32'd2);
        check("halt_rd_data", 32'(bus.read_data), 32'h0032);
        check("halt_ledr",    32'(ledr), 32'h1A5);

        // Reset during RD_WAIT
        @(negedge clk);
        bus.mem_cmd  = MREAD;
        bus.mem_addr = 9'h0FF;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_read_data", 32'(bus.read_data), 32'd0);
        check("mid_ready",     32'(bus.mem_ready), 32'd0);
        check("mid_ledr",      32'(ledr),          32'd0);
        check("mid_bus_err",   32'(bus_err),       32'd0);
        bus.mem_cmd = MNONE;
        @(negedge clk);
        reset = 1'b0;
        rdy_cnt = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            rdy_cnt += int'(bus.mem_ready);
        end
        check("post_rst_no_ready", 32'(rdy_cnt), 32'd0);
        access(MREAD, 9'h0FF, 16'h0000, lat, wec, ra);
        check("post_rst_lat",  32'(lat), 32'd2);
        check("post_rst_data", 32'(bus.read_data), 32'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_io_bridge.md
Name: mem_io_bridge

Overview:
- Memory/I-O bridge sitting directly downstream of the CPU's memory interface, between the CPU and the 256-word RAM and board I-O.
- Decodes each CPU access as RAM, LED register, switch port or unmapped.
- Sequences the 1-cycle synchronous RAM read and returns a one-cycle mem_ready handshake.
- Owns the sticky halt indicator on LEDR[8].

Parameters:
- DATA_W, 16, data width of CPU, RAM and read-back path
- ADDR_W, 9, CPU address width
- RAM_AW, 8, RAM address width; RAM is mapped where addr[8]==0
- LED_ADDR, 9'h100, write-only LED register address
- SW_ADDR, 9'h140, read-only switch port address

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mem_cmd  in  2  CPU command: MNONE=00, MREAD=01, MWRITE=10, 11 illegal
- mem_addr  in  ADDR_W  CPU address; held stable until mem_ready
- write_data  in  DATA_W  CPU write data; held stable until mem_ready
- read_data  out  DATA_W  registered read result; valid while mem_ready=1
- mem_ready  out  1  one-cycle completion pulse, registered
- ram_addr  out  RAM_AW  equals mem_addr[7:0]
- ram_wdata  out  DATA_W  equals write_data
- ram_we  out  1  RAM write strobe
- ram_rdata  in  DATA_W  RAM data, valid one cycle after the address is presented
- sw  in  8  raw board switches, asynchronous
- halt  in  1  CPU halt indication
- ledr  out  9  [7:0] LED register, [8] sticky halt
- bus_err  out  1  sticky error flag

Behaviour:
- Reset (asynchronous): all of the following hold while reset is asserted.
  - state=IDLE
  - read_data=0, mem_ready=0, ledr=0, bus_err=0
  - switch synchroniser flops=0
  - ram_we=0 (gated by reset)
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE:
  - MNONE -> stay in IDLE.
  - MREAD to RAM -> RD_WAIT.
  - MREAD to SW_ADDR -> read_data<={8'h00,sw_sync}; go to RESP.
  - MREAD unmapped -> read_data<=0; bus_err<=1; go to RESP.
  - MWRITE to RAM -> ram_we=1 combinationally during this cycle only; go to RESP.
  - MWRITE to LED_ADDR -> ledr[7:0]<=write_data[7:0]; go to RESP.
  - MWRITE unmapped or to SW_ADDR -> no side effect; bus_err<=1; go to RESP.
  - cmd 11 -> bus_err<=1; stay in IDLE; no mem_ready.
- RD_WAIT: read_data<=ram_rdata at the edge; go to RESP.
- RESP:
  - mem_ready=1 for exactly this cycle.
  - mem_cmd is ignored.
  - Unconditionally return to IDLE.
- Latency, counted in cycles from the accepting IDLE edge to the cycle mem_ready is high:
  - RAM read: 2
  - All other completed accesses: 1
  - Minimum spacing between accepted accesses: RAM read 3 cycles, others 2 cycles.
- read_data holds its value until the next read completes. Writes do not modify read_data.
- ram_we is never asserted outside IDLE. This guarantees exactly one write per MWRITE.
- Address 9'h0FF is RAM. Any address with addr[8]=1, other than LED_ADDR or SW_ADDR, is unmapped.
- sw passes through a 2-flop synchroniser. A switch change is visible to reads 2 edges later.
- ledr[8]:
  - Set on any clk edge where halt=1.
  - Cleared only by reset.
  - Halt does not block bus traffic.
- bus_err is sticky and cleared only by reset.
- Reset during RD_WAIT or RESP: the transaction is abandoned, and no mem_ready is issued after reset deasserts.

Decomposition:
- Package mem_io_pkg:
  - mem_cmd_t enum (MNONE, MREAD, MWRITE)
  - bridge_state_t enum (IDLE, RD_WAIT, RESP)
  - LED_ADDR and SW_ADDR constants
- Sub-module sync2: parameterised-width 2-flop synchroniser, same clk and reset.

Test Plan:
- RAM read: preload RAM[8'h05]=16'h0032, then MREAD addr 9'h005 -> mem_ready high exactly 2 cycles after accept with read_data=16'h0032, then low the next cycle.
- RAM write then read: MWRITE addr 9'h0FF data 16'hBEEF -> ram_we high for one cycle with ram_addr=8'hFF; a following MREAD 9'h0FF returns 16'hBEEF.
- LED and switches:
  - MWRITE 9'h100 data 16'h12A5 -> ledr[7:0]=8'hA5.
  - Set sw=8'h3C, wait 2 cycles, MREAD 9'h140 -> read_data=16'h003C, 1-cycle latency.
- Errors:
  - MREAD 9'h1FF -> read_data=0, bus_err=1.
  - mem_cmd=11 -> no mem_ready, bus_err stays 1 until reset.
  - MWRITE 9'h140 -> no ledr change.
- Halt: pulse halt for 1 cycle -> ledr[8]=1 and stays 1; subsequent RAM reads still complete normally.
- Reset mid-read: assert reset during RD_WAIT -> immediately read_data=0, mem_ready=0, ledr=0, bus_err=0; after release no spurious mem_ready; a new MREAD completes normally.
